// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// The state encodings, master indices and default widths live here so the top and the picker agree on them.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MASK_W_DEF = 8;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker.
// On a tie it selects the index that did not win last time.
module arb_rr2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    always_comb begin
        any = |req;
        if (&req) begin
            gnt_idx = ~last;
        end else if (req[M_LSU]) begin
            gnt_idx = M_LSU;
        end else begin
            gnt_idx = M_IFU;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single core memory port between IFU (master 0) and LSU (master 1).
// One transaction is outstanding at a time, and the grant is held from request through response.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wen,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [MASK_W-1:0] m0_wmask,
    output logic              m0_resp_valid,
    input  logic              m0_resp_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wen,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [MASK_W-1:0] m1_wmask,
    output logic              m1_resp_valid,
    input  logic              m1_resp_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wen,
    output logic [DATA_W-1:0] s_wdata,
    output logic [MASK_W-1:0] s_wmask,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_err,

    output logic              grant_o,
    output logic              busy_o
);

    state_t state, state_next;
    logic   grant, grant_next;
    logic   last_grant, last_next;
    logic   arb_gnt, arb_any;
    logic   sel_req_valid, sel_resp_ready;

    arb_rr2 u_arb (
        .req     ({m1_req_valid, m0_req_valid}),
        .last    (last_grant),
        .gnt_idx (arb_gnt),
        .any     (arb_any)
    );

    assign sel_req_valid  = (grant == M_LSU) ? m1_req_valid  : m0_req_valid;
    assign sel_resp_ready = (grant == M_LSU) ? m1_resp_ready : m0_resp_ready;

    // last_grant resets to LSU so the IFU wins the very first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= M_IFU;
            last_grant <= M_LSU;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_next;
        end
    end

    // A request dropped in REQ is a flush: no slave transaction, and fairness history is untouched.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last_grant;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_next = ST_REQ;
                    grant_next = arb_gnt;
                end
            end
            ST_REQ: begin
                if (!sel_req_valid) begin
                    state_next = ST_IDLE;
                end else if (s_req_ready) begin
                    state_next = ST_RESP;
                    last_next  = grant;
                end
            end
            ST_RESP: begin
                if (s_resp_valid && sel_resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_req_valid   = 1'b0;
        s_addr        = '0;
        s_wen         = 1'b0;
        s_wdata       = '0;
        s_wmask       = '0;
        s_resp_ready  = 1'b0;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_rdata      = '0;
        m1_rdata      = '0;
        m0_err        = 1'b0;
        m1_err        = 1'b0;
        case (state)
            ST_REQ: begin
                s_req_valid  = sel_req_valid;
                s_addr       = (grant == M_LSU) ? m1_addr  : m0_addr;
                s_wen        = (grant == M_LSU) ? m1_wen   : m0_wen;
                s_wdata      = (grant == M_LSU) ? m1_wdata : m0_wdata;
                s_wmask      = (grant == M_LSU) ? m1_wmask : m0_wmask;
                m0_req_ready = (grant == M_IFU) && s_req_ready;
                m1_req_ready = (grant == M_LSU) && s_req_ready;
            end
            ST_RESP: begin
                s_resp_ready = sel_resp_ready;
                if (grant == M_LSU) begin
                    m1_resp_valid = s_resp_valid;
                    m1_rdata      = s_rdata;
                    m1_err        = s_err;
                end else begin
                    m0_resp_valid = s_resp_valid;
                    m0_rdata      = s_rdata;
                    m0_err        = s_err;
                end
            end
            default: ;
        endcase
    end

    assign grant_o = grant;
    assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic.
// A transaction-level model (owner / accepted / last served) predicts every output each cycle.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  req_valid;
    logic [1:0]  wen;
    logic [1:0]  resp_ready;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [7:0]  wmask [2];

    logic        s_req_ready;
    logic        s_resp_valid;
    logic [31:0] s_rdata;
    logic        s_err;

    logic        m0_req_ready, m1_req_ready;
    logic        m0_resp_valid, m1_resp_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_err, m1_err;
    logic        s_req_valid, s_wen, s_resp_ready;
    logic [31:0] s_addr, s_wdata;
    logic [7:0]  s_wmask;
    logic        grant_o, busy_o;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: owner is -1 when the bus is free, accepted means the slave has taken the request.
    int   mo_owner = -1;
    bit   mo_acc   = 1'b0;
    int   mo_last  = 1;
    logic mo_grant = 1'b0;

    mem_bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_valid  (req_valid[0]),
        .m0_req_ready  (m0_req_ready),
        .m0_addr       (addr[0]),
        .m0_wen        (wen[0]),
        .m0_wdata      (wdata[0]),
        .m0_wmask      (wmask[0]),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (resp_ready[0]),
        .m0_rdata      (m0_rdata),
        .m0_err        (m0_err),
        .m1_req_valid  (req_valid[1]),
        .m1_req_ready  (m1_req_ready),
        .m1_addr       (addr[1]),
        .m1_wen        (wen[1]),
        .m1_wdata      (wdata[1]),
        .m1_wmask      (wmask[1]),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (resp_ready[1]),
        .m1_rdata      (m1_rdata),
        .m1_err        (m1_err),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_addr        (s_addr),
        .s_wen         (s_wen),
        .s_wdata       (s_wdata),
        .s_wmask       (s_wmask),
        .s_resp_valid  (s_resp_valid),
        .s_resp_ready  (s_resp_ready),
        .s_rdata       (s_rdata),
        .s_err         (s_err),
        .grant_o       (grant_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model update on each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            mo_owner = -1;
            mo_acc   = 1'b0;
            mo_last  = 1;
            mo_grant = 1'b0;
        end else if (mo_owner < 0) begin
            if (req_valid == 2'b11)   mo_owner = 1 - mo_last;
            else if (req_valid[0])    mo_owner = 0;
            else if (req_valid[1])    mo_owner = 1;
            if (mo_owner >= 0) begin
                mo_grant = (mo_owner == 1);
                mo_acc   = 1'b0;
            end
        end else if (!mo_acc) begin
            if (!req_valid[mo_owner]) begin
                mo_owner = -1;
            end else if (s_req_ready) begin
                mo_acc  = 1'b1;
                mo_last = mo_owner;
            end
        end else if (s_resp_valid && resp_ready[mo_owner]) begin
            mo_owner = -1;
            mo_acc   = 1'b0;
        end
    end

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        bit in_req, in_resp, is0, is1;
        int sel;
        if (check_en) begin
            sel     = (mo_owner >= 0) ? mo_owner : 0;
            in_req  = (mo_owner >= 0) && !mo_acc;
            in_resp = (mo_owner >= 0) && mo_acc;
            is0     = (mo_owner == 0);
            is1     = (mo_owner == 1);
            checkOutput("busy_o",        busy_o,        mo_owner >= 0);
            checkOutput("grant_o",       grant_o,       mo_grant);
            checkOutput("s_req_valid",   s_req_valid,   in_req && req_valid[sel]);
            checkOutput("s_addr",        s_addr,        in_req ? addr[sel]  : 32'h0);
            checkOutput("s_wen",         s_wen,         in_req ? wen[sel]   : 1'b0);
            checkOutput("s_wdata",       s_wdata,       in_req ? wdata[sel] : 32'h0);
            checkOutput("s_wmask",       s_wmask,       in_req ? wmask[sel] : 8'h0);
            checkOutput("s_resp_ready",  s_resp_ready,  in_resp && resp_ready[sel]);
            checkOutput("m0_req_ready",  m0_req_ready,  in_req && is0 && s_req_ready);
            checkOutput("m1_req_ready",  m1_req_ready,  in_req && is1 && s_req_ready);
            checkOutput("m0_resp_valid", m0_resp_valid, in_resp && is0 && s_resp_valid);
            checkOutput("m1_resp_valid", m1_resp_valid, in_resp && is1 && s_resp_valid);
            checkOutput("m0_rdata",      m0_rdata,      (in_resp && is0) ? s_rdata : 32'h0);
            checkOutput("m1_rdata",      m1_rdata,      (in_resp && is1) ? s_rdata : 32'h0);
            checkOutput("m0_err",        m0_err,        in_resp && is0 && s_err);
            checkOutput("m1_err",        m1_err,        in_resp && is1 && s_err);
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req_valid    = 2'b00;
        wen          = 2'b00;
        resp_ready   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
            wmask[i] = 8'h0;
        end
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        s_rdata      = 32'h0;
        s_err        = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        stepCycle();
        stepCycle();
        rst = 1'b0;
        check_en = 1'b1;
    endtask

    task automatic applyStimulus();
        rst          = ($urandom_range(0, 199) == 0);
        req_valid[0] = ($urandom_range(0, 9) < 6);
        req_valid[1] = ($urandom_range(0, 9) < 6);
        resp_ready[0] = ($urandom_range(0, 9) < 7);
        resp_ready[1] = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < 2; i++) begin
            wen[i]   = ($urandom_range(0, 1) == 1);
            addr[i]  = $urandom();
            wdata[i] = $urandom();
            wmask[i] = 8'($urandom());
        end
        s_req_ready  = ($urandom_range(0, 1) == 1);
        s_resp_valid = ($urandom_range(0, 1) == 1);
        s_rdata      = $urandom();
        s_err        = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        int grants[$];
        int pulses;
        bit seen;

        idleInputs();

        // Single IFU read: bubble cycle, request cycle, response cycle.
        doReset();
        checkOutput("reset_grant_o", grant_o, 1'b0);
        checkOutput("reset_busy_o", busy_o, 1'b0);
        req_valid[0]  = 1'b1;
        addr[0]       = 32'h8000_0000;
        resp_ready[0] = 1'b1;
        s_req_ready   = 1'b1;
        s_resp_valid  = 1'b1;
        s_rdata       = 32'h0000_0413;
        @(negedge clk);
        checkOutput("t1_bubble_s_req_valid", s_req_valid, 1'b0);
        stepCycle();
        @(negedge clk);
        checkOutput("t1_s_req_valid", s_req_valid, 1'b1);
        checkOutput("t1_s_addr", s_addr, 32'h8000_0000);
        checkOutput("t1_model_owner", mo_owner, 0);
        stepCycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("t1_m0_resp_valid", m0_resp_valid, 1'b1);
        checkOutput("t1_m0_rdata", m0_rdata, 32'h0000_0413);
        checkOutput("t1_m1_rdata", m1_rdata, 32'h0);
        stepCycle();
        @(negedge clk);
        checkOutput("t1_busy_after", busy_o, 1'b0);

        // Persistent tie: owners must alternate IFU, LSU, IFU, LSU.
        doReset();
        req_valid    = 2'b11;
        resp_ready   = 2'b11;
        s_req_ready  = 1'b1;
        s_resp_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (s_req_valid && s_req_ready) grants.push_back(int'(grant_o));
            stepCycle();
        end
        checkOutput("t2_handshake_count", grants.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            checkOutput($sformatf("t2_owner_%0d", i), grants[i], i % 2);

        // LSU write stalled by the slave while IFU is also waiting.
        doReset();
        req_valid[1] = 1'b1;
        wen[1]       = 1'b1;
        addr[1]      = 32'h8000_1000;
        wdata[1]     = 32'hDEAD_BEEF;
        wmask[1]     = 8'h0F;
        stepCycle();
        req_valid[0] = 1'b1;
        addr[0]      = 32'h1111_2222;
        pulses       = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("t3_s_addr", s_addr, 32'h8000_1000);
            checkOutput("t3_s_wdata", s_wdata, 32'hDEAD_BEEF);
            checkOutput("t3_s_wmask", s_wmask, 8'h0F);
            checkOutput("t3_s_wen", s_wen, 1'b1);
            checkOutput("t3_m0_req_ready", m0_req_ready, 1'b0);
            if (m1_req_ready) pulses++;
            stepCycle();
        end
        s_req_ready = 1'b1;
        @(negedge clk);
        if (m1_req_ready) pulses++;
        stepCycle();
        req_valid[1] = 1'b0;
        s_req_ready  = 1'b0;
        @(negedge clk);
        if (m1_req_ready) pulses++;
        checkOutput("t3_m1_ready_pulses", pulses, 1);
        idleInputs();
        stepCycle();

        // IFU flushes its request before acceptance; the next tie still goes to IFU.
        doReset();
        req_valid[0] = 1'b1;
        stepCycle();
        @(negedge clk);
        checkOutput("t4_s_req_valid", s_req_valid, 1'b1);
        stepCycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("t4_flush_s_req_valid", s_req_valid, 1'b0);
        stepCycle();
        @(negedge clk);
        checkOutput("t4_flush_idle", busy_o, 1'b0);
        checkOutput("t4_model_last", mo_last, 1);
        stepCycle();
        req_valid   = 2'b11;
        s_req_ready = 1'b1;
        stepCycle();
        @(negedge clk);
        checkOutput("t4_tie_grant", grant_o, 1'b0);
        idleInputs();
        stepCycle();
        stepCycle();

        // Error response held while the LSU back-pressures.
        doReset();
        req_valid[1] = 1'b1;
        s_req_ready  = 1'b1;
        stepCycle();
        stepCycle();
        req_valid[1]  = 1'b0;
        s_req_ready   = 1'b0;
        s_resp_valid  = 1'b1;
        s_err         = 1'b1;
        resp_ready[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("t5_m1_err", m1_err, 1'b1);
            checkOutput("t5_m1_resp_valid", m1_resp_valid, 1'b1);
            checkOutput("t5_s_resp_ready", s_resp_ready, 1'b0);
            stepCycle();
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        checkOutput("t5_s_resp_ready_rel", s_resp_ready, 1'b1);
        stepCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("t5_idle", busy_o, 1'b0);

        // Reset in the middle of a response wait, then a fresh transaction.
        doReset();
        req_valid[0]  = 1'b1;
        resp_ready[0] = 1'b1;
        s_req_ready   = 1'b1;
        stepCycle();
        stepCycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy_in_resp", busy_o, 1'b1);
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy_reset", busy_o, 1'b0);
        checkOutput("t6_s_req_valid", s_req_valid, 1'b0);
        checkOutput("t6_s_resp_ready", s_resp_ready, 1'b0);
        checkOutput("t6_m0_req_ready", m0_req_ready, 1'b0);
        checkOutput("t6_m0_resp_valid", m0_resp_valid, 1'b0);
        stepCycle();
        req_valid[0] = 1'b1;
        addr[0]      = 32'h8000_0040;
        s_resp_valid = 1'b1;
        s_rdata      = 32'h0000_1234;
        seen         = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (m0_resp_valid) begin
                seen = 1'b1;
                checkOutput("t6_fresh_rdata", m0_rdata, 32'h0000_1234);
            end
            stepCycle();
        end
        checkOutput("t6_fresh_done", seen, 1'b1);
        idleInputs();

        // Randomized traffic checked cycle by cycle against the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            stepCycle();
        end
        rst = 1'b0;
        idleInputs();
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
